// File: rtl/cr_huf_comp_st_lut_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_huf_comp_st_lut_arb_if
// Purpose  : Builder-side write streams and shared LUT write port of the
//            symbol-table LUT arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cr_huf_comp_st_lut_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*DATA_W-1:0] ch_wr_data;
    logic [NUM_CH-1:0]        ch_wr_done;
    logic [NUM_CH-1:0]        ch_full;
    logic                     lut_wr;
    logic [DATA_W-1:0]        lut_wr_data;
    logic                     lut_wr_done;
    logic [CH_W-1:0]          lut_wr_ch;
    logic                     lut_full;

    // The master side is the builders plus the LUT; the slave is the arbiter.
    modport master (
        output ch_wr, ch_wr_data, ch_wr_done, lut_full,
        input  ch_full, lut_wr, lut_wr_data, lut_wr_done, lut_wr_ch
    );

    modport slave (
        input  ch_wr, ch_wr_data, ch_wr_done, lut_full,
        output ch_full, lut_wr, lut_wr_data, lut_wr_done, lut_wr_ch
    );
endinterface
`default_nettype wire

// File: rtl/cr_huf_comp_st_lut_arb.sv
`default_nettype none
// ============================================================================
// Module   : cr_huf_comp_st_lut_arb
// Purpose  : Frame-atomic round-robin arbiter merging NUM_CH builder LUT
//            write streams onto one shared LUT write port, with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cr_huf_comp_st_lut_arb #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cr_huf_comp_st_lut_arb_if.slave bus,
    output logic [NUM_CH-1:0]      timeout_err,
    output logic                   busy
);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_SCAN_W = CH_W + 1;
    localparam int c_CNT_W  = 10;

    localparam logic [0:0]          c_ST_IDLE  = 1'b0;
    localparam logic [0:0]          c_ST_GRANT = 1'b1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]     c_CH_LAST  = CH_W'(NUM_CH - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CH_W-1:0]     r_owner;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [c_CNT_W-1:0]  r_idle_cnt;
    logic                r_lut_wr;
    logic                r_lut_wr_done;
    logic [DATA_W-1:0]   r_lut_wr_data;
    logic [CH_W-1:0]     r_lut_wr_ch;
    logic [NUM_CH-1:0]   r_timeout_err;

    logic                w_grant;
    logic                w_req_any;
    logic                w_accept;
    logic                w_done_beat;
    logic                w_timeout;
    logic                w_release;
    logic [CH_W-1:0]     w_pick;
    logic [CH_W-1:0]     w_owner_inc;
    logic [c_SCAN_W-1:0] w_scan;
    logic [DATA_W-1:0]   w_beat;
    logic [NUM_CH-1:0]   w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_req_any) w_state_nxt = c_ST_GRANT;
            c_ST_GRANT: if (w_release) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant     = (r_state == c_ST_GRANT);
        w_accept    = w_grant && bus.ch_wr[r_owner] && !bus.lut_full;
        w_done_beat = bus.ch_wr_done[r_owner];
        // An accepted beat in the last watchdog cycle wins over the timeout.
        w_timeout   = w_grant && !w_accept && (r_idle_cnt == c_CNT_LAST);
        w_release   = (w_accept && w_done_beat) || w_timeout;
        busy        = w_grant;
        w_full      = '0;
        w_beat      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_full[i] = !(w_grant && (r_owner == CH_W'(i))) || bus.lut_full;
            if (r_owner == CH_W'(i)) w_beat = bus.ch_wr_data[i*DATA_W +: DATA_W];
        end
    end

    // Descending scan so the requester closest above rr_ptr is the last writer.
    always_comb begin
        w_req_any = |bus.ch_wr;
        w_pick    = r_rr_ptr;
        w_scan    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + c_SCAN_W'(k);
            if (w_scan >= c_SCAN_W'(NUM_CH)) w_scan = w_scan - c_SCAN_W'(NUM_CH);
            if (bus.ch_wr[w_scan[CH_W-1:0]]) w_pick = w_scan[CH_W-1:0];
        end
        w_owner_inc = (r_owner == c_CH_LAST) ? '0 : r_owner + CH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_idle_cnt    <= '0;
            r_lut_wr      <= 1'b0;
            r_lut_wr_done <= 1'b0;
            r_lut_wr_data <= '0;
            r_lut_wr_ch   <= '0;
            r_timeout_err <= '0;
        end else begin
            r_lut_wr      <= w_accept;
            r_timeout_err <= '0;
            if (w_accept) begin
                r_lut_wr_data <= w_beat;
                r_lut_wr_done <= w_done_beat;
                r_lut_wr_ch   <= r_owner;
            end
            if (w_timeout) r_timeout_err[r_owner] <= 1'b1;
            if (!w_grant && w_req_any) r_owner <= w_pick;
            if (w_release) r_rr_ptr <= w_owner_inc;
            // A LUT stall freezes the watchdog rather than counting as idleness.
            if (!w_grant || w_accept) begin
                r_idle_cnt <= '0;
            end else if (!bus.lut_full) begin
                r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus.ch_full     = w_full;
    assign bus.lut_wr      = r_lut_wr;
    assign bus.lut_wr_data = r_lut_wr_data;
    assign bus.lut_wr_done = r_lut_wr_done;
    assign bus.lut_wr_ch   = r_lut_wr_ch;
    assign timeout_err     = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_st_lut_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_huf_comp_st_lut_arb
// Purpose  : Directed self-checking bench for the LUT write arbiter
//            (NUM_CH=4, DATA_W=32, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_huf_comp_st_lut_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] terr;
    logic       busy;
    int         n_checks = 0;
    int         n_pass   = 0;

    cr_huf_comp_st_lut_arb_if #(.NUM_CH(4), .DATA_W(32)) bus ();

    cr_huf_comp_st_lut_arb #(.NUM_CH(4), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .timeout_err (terr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // obs = {lut_wr, lut_wr_done, lut_wr_ch, lut_wr_data}; ctl = {ch_full, timeout_err, busy}
    logic [35:0] obs;
    logic [8:0]  ctl;
    logic [35:0] exp_o;
    logic [8:0]  exp_c;
    assign obs = {bus.lut_wr, bus.lut_wr_done, bus.lut_wr_ch, bus.lut_wr_data};
    assign ctl = {bus.ch_full, terr, busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic wr, input logic done, input logic [31:0] d);
        bus.ch_wr[ch]             = wr;
        bus.ch_wr_done[ch]        = done;
        bus.ch_wr_data[ch*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.lut_full   = 1'b0;
        bus.ch_wr      = 4'hF;
        bus.ch_wr_done = 4'h0;
        bus.ch_wr_data = '0;
        tick(); tick(); tick();
        exp_o = '0;
        n_checks++; if (obs !== exp_o) $display("FAIL reset_obs: got %h want %h", obs, exp_o); else n_pass++;
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL reset_ctl: got %h want %h", ctl, exp_c); else n_pass++;
        bus.ch_wr = 4'h0;
    endtask

    task automatic test_two_requesters();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'hA000_0000);
        drive(2, 1'b1, 1'b0, 32'hC000_0000);
        tick();
        exp_c = {4'b1110, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_grant0: got %h want %h", ctl, exp_c); else n_pass++;
        n_checks++; if (obs !== 36'h0) $display("FAIL two_arb_nowr: got %h want %h", obs, 36'h0); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd0, 32'hA000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL two_a0: got %h want %h", obs, exp_o); else n_pass++;
        drive(0, 1'b1, 1'b1, 32'hA000_0001);
        tick();
        exp_o = {1'b1, 1'b1, 2'd0, 32'hA000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL two_a1: got %h want %h", obs, exp_o); else n_pass++;
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_idle: got %h want %h", ctl, exp_c); else n_pass++;
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
        exp_c = {4'b1011, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_grant2: got %h want %h", ctl, exp_c); else n_pass++;
        exp_o = {1'b0, 1'b1, 2'd0, 32'hA000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL two_dead_hold: got %h want %h", obs, exp_o); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd2, 32'hC000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL two_c0: got %h want %h", obs, exp_o); else n_pass++;
        drive(2, 1'b1, 1'b1, 32'hC000_0001);
        tick();
        exp_o = {1'b1, 1'b1, 2'd2, 32'hC000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL two_c1: got %h want %h", obs, exp_o); else n_pass++;
        drive(2, 1'b0, 1'b0, 32'h0);
        // one-beat ch0 frame moves rr_ptr to 1, then ch0 and ch2 contend again
        drive(0, 1'b1, 1'b1, 32'hB000_0000);
        tick();
        exp_c = {4'b1110, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_b_grant: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd0, 32'hB000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL two_b0: got %h want %h", obs, exp_o); else n_pass++;
        drive(0, 1'b1, 1'b1, 32'hA000_0002);
        drive(2, 1'b1, 1'b1, 32'hC000_0002);
        tick();
        exp_c = {4'b1011, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_rr1_ch2_first: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd2, 32'hC000_0002};
        n_checks++; if (obs !== exp_o) $display("FAIL two_c2: got %h want %h", obs, exp_o); else n_pass++;
        drive(2, 1'b0, 1'b0, 32'h0);
        tick();
        exp_c = {4'b1110, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL two_rr1_ch0_second: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd0, 32'hA000_0002};
        n_checks++; if (obs !== exp_o) $display("FAIL two_a2: got %h want %h", obs, exp_o); else n_pass++;
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_single_frame();
        drive(1, 1'b1, 1'b0, 32'hD000_0000);
        tick();
        exp_c = {4'b1101, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL sf_grant: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd1, 32'hD000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL sf_d0: got %h want %h", obs, exp_o); else n_pass++;
        drive(1, 1'b1, 1'b0, 32'hD000_0001);
        tick();
        exp_o = {1'b1, 1'b0, 2'd1, 32'hD000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL sf_d1: got %h want %h", obs, exp_o); else n_pass++;
        drive(1, 1'b1, 1'b1, 32'hD000_0002);
        tick();
        exp_o = {1'b1, 1'b1, 2'd1, 32'hD000_0002};
        n_checks++; if (obs !== exp_o) $display("FAIL sf_d2_done: got %h want %h", obs, exp_o); else n_pass++;
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL sf_busy_low: got %h want %h", ctl, exp_c); else n_pass++;
        drive(1, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.lut_wr !== 1'b0) $display("FAIL sf_wr_low: got %b want 0", bus.lut_wr); else n_pass++;
    endtask

    task automatic test_rr_after_frame();
        drive(1, 1'b1, 1'b1, 32'h1111_0001);
        drive(2, 1'b1, 1'b1, 32'h2222_0002);
        tick();
        exp_c = {4'b1011, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL rr_ptr2_ch2: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd2, 32'h2222_0002};
        n_checks++; if (obs !== exp_o) $display("FAIL rr_k2: got %h want %h", obs, exp_o); else n_pass++;
        drive(2, 1'b0, 1'b0, 32'h0);
        tick();
        exp_c = {4'b1101, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL rr_ch1_next: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd1, 32'h1111_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL rr_k1: got %h want %h", obs, exp_o); else n_pass++;
        drive(1, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_lut_full();
        drive(1, 1'b1, 1'b0, 32'hE000_0000);
        tick();
        exp_c = {4'b1101, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL lf_grant: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd1, 32'hE000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL lf_e0: got %h want %h", obs, exp_o); else n_pass++;
        // owner idles 4 cycles, then a 5-cycle stall must not push it to timeout
        drive(1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        drive(1, 1'b1, 1'b0, 32'hE000_0001);
        bus.lut_full = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_c = {4'b1111, 4'b0000, 1'b1};
            n_checks++; if (ctl !== exp_c) $display("FAIL lf_stall_ctl%0d: got %h want %h", k, ctl, exp_c); else n_pass++;
            exp_o = {1'b0, 1'b0, 2'd1, 32'hE000_0000};
            n_checks++; if (obs !== exp_o) $display("FAIL lf_stall_obs%0d: got %h want %h", k, obs, exp_o); else n_pass++;
            if (k == 4) bus.lut_full = 1'b0;
            tick();
        end
        exp_o = {1'b1, 1'b0, 2'd1, 32'hE000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL lf_e1: got %h want %h", obs, exp_o); else n_pass++;
        n_checks++; if (terr !== 4'h0) $display("FAIL lf_no_err: got %h want 0", terr); else n_pass++;
        drive(1, 1'b1, 1'b1, 32'hE000_0002);
        tick();
        exp_o = {1'b1, 1'b1, 2'd1, 32'hE000_0002};
        n_checks++; if (obs !== exp_o) $display("FAIL lf_e2: got %h want %h", obs, exp_o); else n_pass++;
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL lf_end: got %h want %h", ctl, exp_c); else n_pass++;
        drive(1, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        drive(3, 1'b1, 1'b0, 32'hF000_0000);
        tick();
        exp_c = {4'b0111, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL to_grant3: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd3, 32'hF000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL to_f0: got %h want %h", obs, exp_o); else n_pass++;
        drive(3, 1'b0, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h6000_0000);
        tick();
        for (int k = 0; k < 7; k++) begin
            exp_c = {4'b0111, 4'b0000, 1'b1};
            n_checks++; if (ctl !== exp_c) $display("FAIL to_wait%0d: got %h want %h", k, ctl, exp_c); else n_pass++;
            tick();
        end
        exp_c = {4'b1111, 4'b1000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL to_err3: got %h want %h", ctl, exp_c); else n_pass++;
        exp_o = {1'b0, 1'b0, 2'd3, 32'hF000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL to_no_done: got %h want %h", obs, exp_o); else n_pass++;
        tick();
        exp_c = {4'b1110, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL to_grant0: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd0, 32'h6000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL to_g0: got %h want %h", obs, exp_o); else n_pass++;
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_accept_at_timeout();
        drive(2, 1'b1, 1'b0, 32'h7000_0000);
        tick();
        exp_c = {4'b1011, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL at_grant2: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        drive(2, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 7; k++) tick();
        // idle_cnt is TIMEOUT-1 in this cycle; the beat must win
        drive(2, 1'b1, 1'b0, 32'h7000_0001);
        tick();
        exp_o = {1'b1, 1'b0, 2'd2, 32'h7000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL at_h1: got %h want %h", obs, exp_o); else n_pass++;
        exp_c = {4'b1011, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL at_no_err: got %h want %h", ctl, exp_c); else n_pass++;
        drive(2, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 7; k++) begin
            exp_c = {4'b1011, 4'b0000, 1'b1};
            n_checks++; if (ctl !== exp_c) $display("FAIL at_cleared%0d: got %h want %h", k, ctl, exp_c); else n_pass++;
            tick();
        end
        exp_c = {4'b1111, 4'b0100, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL at_err2: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL at_err_pulse: got %h want %h", ctl, exp_c); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        drive(1, 1'b1, 1'b0, 32'h9000_0000);
        tick();
        exp_c = {4'b1101, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL rm_grant: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b0, 2'd1, 32'h9000_0000};
        n_checks++; if (obs !== exp_o) $display("FAIL rm_j0: got %h want %h", obs, exp_o); else n_pass++;
        drive(1, 1'b1, 1'b1, 32'h9000_0001);
        rst = 1'b1;
        tick();
        n_checks++; if (obs !== 36'h0) $display("FAIL rm_obs_zero: got %h want %h", obs, 36'h0); else n_pass++;
        exp_c = {4'b1111, 4'b0000, 1'b0};
        n_checks++; if (ctl !== exp_c) $display("FAIL rm_ctl: got %h want %h", ctl, exp_c); else n_pass++;
        rst = 1'b0;
        drive(1, 1'b1, 1'b1, 32'h5000_0001);
        drive(3, 1'b1, 1'b1, 32'h5000_0003);
        tick();
        exp_c = {4'b1101, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL rm_rr0_ch1: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd1, 32'h5000_0001};
        n_checks++; if (obs !== exp_o) $display("FAIL rm_l1: got %h want %h", obs, exp_o); else n_pass++;
        drive(1, 1'b0, 1'b0, 32'h0);
        tick();
        exp_c = {4'b0111, 4'b0000, 1'b1};
        n_checks++; if (ctl !== exp_c) $display("FAIL rm_ch3_next: got %h want %h", ctl, exp_c); else n_pass++;
        tick();
        exp_o = {1'b1, 1'b1, 2'd3, 32'h5000_0003};
        n_checks++; if (obs !== exp_o) $display("FAIL rm_l3: got %h want %h", obs, exp_o); else n_pass++;
        drive(3, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    initial begin
        bus.ch_wr      = '0;
        bus.ch_wr_done = '0;
        bus.ch_wr_data = '0;
        bus.lut_full   = 1'b0;
        test_reset();
        test_two_requesters();
        test_single_frame();
        test_rr_after_frame();
        test_lut_full();
        test_timeout();
        test_accept_at_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
